// File: rtl/stochastic_result_uart_tx_pkg.sv
// Shared types and defaults for the stochastic result UART transmitter.
// The result word is {over_flag, 9-bit probability}.
package stoch_pkg;

  localparam int          RESULT_W             = 10;
  localparam int          CLKS_PER_BIT_DEFAULT = 8;
  localparam logic [5:0]  MARKER_DEFAULT       = 6'b101000;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } tx_state_t;

endpackage

// File: rtl/stochastic_result_uart_tx_fifo.sv
// Small synchronous FIFO for result words; show-ahead read data.
// A write to a full FIFO is accepted only when a pop happens in the same cycle.
module stoch_result_fifo
  import stoch_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                wr_en,
  input  logic [RESULT_W-1:0] wr_data,
  input  logic                rd_en,
  output logic [RESULT_W-1:0] rd_data,
  output logic                empty,
  output logic                full
);

  localparam int AW = $clog2(DEPTH);

  logic [RESULT_W-1:0] mem [DEPTH];
  logic [AW:0]         wr_ptr;
  logic [AW:0]         rd_ptr;
  logic [AW:0]         count;
  logic                do_wr;
  logic                do_rd;

  assign empty   = (count == '0);
  assign full    = (count == (AW+1)'(DEPTH));
  assign do_rd   = rd_en && !empty;
  assign do_wr   = wr_en && (!full || do_rd);
  assign rd_data = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr[AW-1:0]] <= wr_data;
  end

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + 1'b1;
      if (do_rd) rd_ptr <= rd_ptr + 1'b1;
      case ({do_wr, do_rd})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/stochastic_result_uart_tx.sv
// Sends each captured 10-bit stochastic result as two 8N1 frames:
// B0 = {MARKER, result[9:8]}, B1 = result[7:0].
module stochastic_result_uart_tx
  import stoch_pkg::*;
#(
  parameter int         CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT,
  parameter int         FIFO_DEPTH   = 4,
  parameter logic [5:0] MARKER       = MARKER_DEFAULT
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [RESULT_W-1:0] result_in,
  input  logic                result_valid,
  output logic                tx_out,
  output logic                busy,
  output logic                fifo_full,
  output logic                overflow,
  output logic [7:0]          drop_count
);

  localparam logic [15:0] BIT_RELOAD = 16'(CLKS_PER_BIT - 1);

  tx_state_t           state_q, state_d;
  logic                byte_sel_q, byte_sel_d;
  logic [2:0]          bit_idx_q, bit_idx_d;
  logic [15:0]         timer_q, timer_d;
  logic [RESULT_W-1:0] hold_q, hold_d;
  logic [RESULT_W-1:0] fifo_rd_data;
  logic                fifo_empty;
  logic                pop;
  logic                bit_done;
  logic                drop;
  logic [7:0]          cur_byte;

  stoch_result_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (result_valid),
    .wr_data (result_in),
    .rd_en   (pop),
    .rd_data (fifo_rd_data),
    .empty   (fifo_empty),
    .full    (fifo_full)
  );

  assign bit_done = (timer_q == 16'd0);
  assign cur_byte = byte_sel_q ? hold_q[7:0] : {MARKER, hold_q[9:8]};
  assign busy     = (state_q != IDLE) || !fifo_empty;
  assign drop     = result_valid && fifo_full && !pop;

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      state_q    <= IDLE;
      byte_sel_q <= 1'b0;
      bit_idx_q  <= 3'd0;
      timer_q    <= 16'd0;
      hold_q     <= '0;
    end else begin
      state_q    <= state_d;
      byte_sel_q <= byte_sel_d;
      bit_idx_q  <= bit_idx_d;
      timer_q    <= timer_d;
      hold_q     <= hold_d;
    end
  end

  // tx_out is decoded from state so an async reset returns the line high at once.
  always_comb begin
    state_d    = state_q;
    byte_sel_d = byte_sel_q;
    bit_idx_d  = bit_idx_q;
    timer_d    = timer_q;
    hold_d     = hold_q;
    pop        = 1'b0;
    tx_out     = 1'b1;
    case (state_q)
      IDLE: begin
        if (!fifo_empty) begin
          pop        = 1'b1;
          hold_d     = fifo_rd_data;
          byte_sel_d = 1'b0;
          timer_d    = BIT_RELOAD;
          state_d    = START;
        end
      end
      START: begin
        tx_out = 1'b0;
        if (bit_done) begin
          timer_d   = BIT_RELOAD;
          bit_idx_d = 3'd0;
          state_d   = DATA;
        end else begin
          timer_d = timer_q - 16'd1;
        end
      end
      DATA: begin
        tx_out = cur_byte[bit_idx_q];
        if (bit_done) begin
          timer_d = BIT_RELOAD;
          if (bit_idx_q == 3'd7) state_d = STOP;
          else                   bit_idx_d = bit_idx_q + 3'd1;
        end else begin
          timer_d = timer_q - 16'd1;
        end
      end
      STOP: begin
        tx_out = 1'b1;
        if (bit_done) begin
          timer_d = BIT_RELOAD;
          if (!byte_sel_q) begin
            byte_sel_d = 1'b1;
            state_d    = START;
          end else begin
            state_d = IDLE;
          end
        end else begin
          timer_d = timer_q - 16'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      overflow   <= 1'b0;
      drop_count <= 8'd0;
    end else if (drop) begin
      overflow <= 1'b1;
      if (drop_count != 8'hFF) drop_count <= drop_count + 8'd1;
    end
  end

endmodule

// File: tb/tb_stochastic_result_uart_tx.sv
// Scoreboard bench: stimulus pushes expected bytes, a UART monitor decodes tx_out and compares.
module tb_stochastic_result_uart_tx;

  localparam int CPB = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic [9:0] result_in = '0;
  logic       result_valid = 1'b0;
  logic       tx_out;
  logic       busy;
  logic       fifo_full;
  logic       overflow;
  logic [7:0] drop_count;

  stochastic_result_uart_tx #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(4)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .result_in    (result_in),
    .result_valid (result_valid),
    .tx_out       (tx_out),
    .busy         (busy),
    .fifo_full    (fifo_full),
    .overflow     (overflow),
    .drop_count   (drop_count)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [7:0] b;
    int         delta;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   failures = 0;
  logic mon_abort;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic push_b(input logic [7:0] b, input int delta);
    exp_t e;
    e.b = b;
    e.delta = delta;
    exp_q.push_back(e);
  endtask

  task automatic nclk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic mon_wait(input int n);
    repeat (n) begin
      @(negedge clk);
      if (rst_n) mon_abort = 1'b1;
    end
  endtask

  task automatic wait_idle(input string name, input int limit);
    int n;
    n = 0;
    while (busy !== 1'b0 && n < limit) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (busy !== 1'b0) begin
      failures++;
      $display("FAIL %s: busy still %b after %0d cycles, required 0", name, busy, limit);
    end
    nclk(5);
  endtask

  // UART monitor: detects the start bit at a falling edge and samples mid-bit.
  initial begin : monitor
    int         t0;
    int         last_t0;
    logic [7:0] rx;
    exp_t       e;
    last_t0 = -1000;
    forever begin
      @(negedge clk);
      if (!rst_n && tx_out === 1'b0) begin
        t0 = cyc;
        mon_abort = 1'b0;
        rx = '0;
        mon_wait(2);
        if (!mon_abort) chk("start_bit", 32'(tx_out), 32'd0);
        for (int i = 0; i < 8; i++) begin
          if (!mon_abort) begin
            mon_wait(CPB);
            rx[i] = tx_out;
          end
        end
        if (!mon_abort) mon_wait(CPB);
        if (!mon_abort) begin
          chk("stop_bit", 32'(tx_out), 32'd1);
          if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_frame: got %02h required none", rx);
          end else begin
            e = exp_q.pop_front();
            chk("frame_byte", 32'(rx), 32'(e.b));
            if (e.delta != 0) chk("frame_spacing", 32'(t0 - last_t0), 32'(e.delta));
          end
        end
        last_t0 = t0;
      end
    end
  end

  logic [9:0] t3_words [7];

  initial begin
    t3_words[0] = 10'h001; t3_words[1] = 10'h102; t3_words[2] = 10'h203;
    t3_words[3] = 10'h304; t3_words[4] = 10'h0F5; t3_words[5] = 10'h3EE;
    t3_words[6] = 10'h2C7;

    // Reset state
    nclk(3);
    chk("rst_tx_out", 32'(tx_out), 32'd1);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_fifo_full", 32'(fifo_full), 32'd0);
    chk("rst_overflow", 32'(overflow), 32'd0);
    chk("rst_drop_count", 32'(drop_count), 32'd0);
    rst_n = 1'b0;
    nclk(3);

    // 1: single result 0x2A5 -> A2, A5; 80 cycles of line time
    push_b(8'hA2, 0);
    push_b(8'hA5, 40);
    result_in = 10'h2A5; result_valid = 1'b1;
    nclk(1);
    result_valid = 1'b0;
    nclk(80);
    chk("t1_busy_last_stop", 32'(busy), 32'd1);
    nclk(1);
    chk("t1_busy_done", 32'(busy), 32'd0);
    chk("t1_tx_idle", 32'(tx_out), 32'd1);
    nclk(3);
    chk("t1_tx_stays_high", 32'(tx_out), 32'd1);
    wait_idle("t1_idle", 200);

    // 2: two consecutive strobes, one idle cycle between results
    push_b(8'hA3, 0);
    push_b(8'hFF, 40);
    push_b(8'hA0, 41);
    push_b(8'h00, 40);
    result_in = 10'h3FF; result_valid = 1'b1;
    nclk(1);
    result_in = 10'h000;
    nclk(1);
    result_valid = 1'b0;
    wait_idle("t2_idle", 400);

    // 3 + 4: six strobes (6th dropped), then a strobe on the cycle IDLE pops
    push_b(8'hA0, 0);   push_b(8'h01, 40);
    push_b(8'hA1, 41);  push_b(8'h02, 40);
    push_b(8'hA2, 41);  push_b(8'h03, 40);
    push_b(8'hA3, 41);  push_b(8'h04, 40);
    push_b(8'hA0, 41);  push_b(8'hF5, 40);
    push_b(8'hA2, 41);  push_b(8'hC7, 40);
    for (int i = 0; i < 6; i++) begin
      result_in = t3_words[i]; result_valid = 1'b1;
      nclk(1);
    end
    result_valid = 1'b0;
    chk("t3_fifo_full", 32'(fifo_full), 32'd1);
    chk("t3_overflow", 32'(overflow), 32'd1);
    chk("t3_drop_count", 32'(drop_count), 32'd1);
    nclk(76);
    chk("t4_full_before_pop", 32'(fifo_full), 32'd1);
    result_in = t3_words[6]; result_valid = 1'b1;
    nclk(1);
    result_valid = 1'b0;
    chk("t4_full_after_pop_write", 32'(fifo_full), 32'd1);
    chk("t4_drop_count_unchanged", 32'(drop_count), 32'd1);
    chk("t4_busy", 32'(busy), 32'd1);
    wait_idle("t3_idle", 1000);

    // 5: reset during bit 3 of B1
    push_b(8'hA2, 0);  push_b(8'hA5, 40);
    push_b(8'hA2, 41); push_b(8'hA5, 40);
    result_in = 10'h2A5; result_valid = 1'b1;
    nclk(1);
    result_in = 10'h2A5;
    nclk(1);
    result_valid = 1'b0;
    nclk(57);
    #1;
    chk("t5_tx_bit3_low", 32'(tx_out), 32'd0);
    rst_n = 1'b1;
    #1;
    chk("t5_tx_high_async", 32'(tx_out), 32'd1);
    chk("t5_busy", 32'(busy), 32'd0);
    chk("t5_fifo_full", 32'(fifo_full), 32'd0);
    chk("t5_overflow_cleared", 32'(overflow), 32'd0);
    chk("t5_drop_count_cleared", 32'(drop_count), 32'd0);
    exp_q.delete();
    nclk(2);
    rst_n = 1'b0;
    nclk(3);
    push_b(8'hA1, 0);
    push_b(8'hC3, 40);
    result_in = 10'h1C3; result_valid = 1'b1;
    nclk(1);
    result_valid = 1'b0;
    wait_idle("t5_idle", 200);

    // 6: 310 back-to-back strobes; 8 accepted, 302 dropped -> saturates at 255
    for (int i = 0; i < 8; i++) begin
      push_b(8'hA1, (i == 0) ? 0 : 41);
      push_b(8'h55, 40);
    end
    result_in = 10'h155; result_valid = 1'b1;
    nclk(310);
    result_valid = 1'b0;
    chk("t6_drop_count_sat", 32'(drop_count), 32'd255);
    chk("t6_overflow", 32'(overflow), 32'd1);
    wait_idle("t6_idle", 1000);
    chk("t6_drop_count_held", 32'(drop_count), 32'd255);
    chk("queue_drained", 32'(exp_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/stochastic_result_uart_tx.md
Name: stochastic_result_uart_tx

Overview:
Downstream stage of the stochastic multiplier. Captures each 10-bit averaged result word when its update strobe fires, buffers it in a small FIFO, and sends it off-chip as two UART 8N1 frames on one pin. The stochastic result is readable with a plain serial adapter, with no need to sample ten parallel pins on the correct cycle.

Parameters:
CLKS_PER_BIT, 8, clk cycles per UART bit; legal values are 2..65535.
FIFO_DEPTH, 4, number of result words buffered; must be a power of two, at least 2.
MARKER, 6'b101000, constant placed in the upper 6 bits of the first byte of each result.

Ports:
clk  input  1  clock
rst_n  input  1  reset: asynchronous, active-high (1 = reset), despite the name
result_in  input  10  {over_flag, 9-bit probability} from the multiplier
result_valid  input  1  one-cycle strobe: result_in is new this cycle
tx_out  output  1  UART line, idles high
busy  output  1  high while a frame is in progress or the FIFO is not empty
fifo_full  output  1  FIFO occupancy equals FIFO_DEPTH
overflow  output  1  sticky; set when a result is dropped
drop_count  output  8  number of dropped results, saturates at 255

Behaviour:
- Reset (asynchronous, takes effect immediately):
  - tx_out=1, busy=0, fifo_full=0, overflow=0, drop_count=0.
  - FIFO is emptied; FSM goes to IDLE.
  - If reset arrives mid-frame, the line returns high at once and the partial frame is abandoned.
- Capture: on a clk edge with result_valid=1, result_in is written to the FIFO tail.
- Full FIFO:
  - If the FIFO is full and no pop happens in the same cycle, the write is dropped, overflow is set, and drop_count increments (saturating at 255).
  - If the FIFO is full and a pop happens in the same cycle, the write is accepted. Occupancy stays at FIFO_DEPTH.
- Empty FIFO: a write and a pop cannot occur in the same cycle. A pop requires the FIFO to be non-empty at the start of the cycle.
- Byte mapping:
  - B0 = {MARKER, result[9:8]}.
  - B1 = result[7:0].
  - Each byte is sent as: start bit 0, data bits LSB first, stop bit 1.
- FSM states: IDLE, START, DATA, STOP. A byte-select flag (0 = B0, 1 = B1) and a bit index 0..7 track progress.
  - IDLE: tx_out=1. If the FIFO is non-empty, pop the head word into a 10-bit hold register, clear byte-select, and go to START.
  - START: tx_out=0 for CLKS_PER_BIT cycles, then go to DATA with bit index 0.
  - DATA: tx_out = current byte[bit index]. Each bit lasts CLKS_PER_BIT cycles. After bit 7, go to STOP.
  - STOP: tx_out=1 for CLKS_PER_BIT cycles.
    - If byte-select=0: set it to 1 and go to START. There is no gap between B0 and B1.
    - If byte-select=1: go to IDLE.
- Latency:
  - result_valid at edge N makes the FIFO non-empty after N.
  - IDLE pops at edge N+1, and tx_out falls after edge N+1.
  - One result occupies exactly 20*CLKS_PER_BIT cycles of line time.
  - IDLE then lasts at least one cycle before the next pop, so successive results are separated by at least one idle-high cycle.
- Bit timer: a 16-bit down-counter reloaded with CLKS_PER_BIT-1 on every bit boundary. Bit transitions happen when it reaches 0.
- busy = (state != IDLE) | FIFO non-empty.
- The hold register protects the word in flight: FIFO writes during transmission never disturb the current frame.
- overflow and drop_count are cleared only by reset.

Decomposition:
- Shared package stoch_pkg holds:
  - the state enum (IDLE/START/DATA/STOP);
  - the MARKER default;
  - RESULT_W=10;
  - the default CLKS_PER_BIT.
- One sub-module, stoch_result_fifo: a synchronous FIFO with the same clk and rst_n.
  - Ports: wr_en, wr_data[9:0], rd_en, rd_data[9:0], empty, full.
  - Internally: pointers one bit wider than the address, plus a count.
  - The top level holds the FSM, bit timer, overflow logic and drop counter.

Test Plan (CLKS_PER_BIT=4, FIFO_DEPTH=4):
1. Send result_in=10'h2A5 as a single strobe. tx_out shows B0=0xA2 then B1=0xA5, each framed as 0, LSB first, 1, with 4 cycles per bit. The full result takes 80 cycles, then tx_out stays high and busy=0.
2. Send 10'h3FF and then 10'h000 on consecutive cycles. The line carries frames 0xA3, 0xFF, 0xA0, 0x00 in order, with exactly one idle-high cycle between the two results.
3. Send 6 strobes back-to-back while the first frame is in progress. One word is popped into the hold register and four fill the FIFO, so fifo_full=1; the 6th is dropped. Expect overflow=1 and drop_count=1, and the five accepted words are transmitted in order.
4. With the FIFO full, assert a strobe on the same cycle IDLE pops. The write is accepted, drop_count does not change, and occupancy stays at 4.
5. Assert rst_n during bit 3 of B1. tx_out goes high within the same cycle (asynchronously), busy=0, and the FIFO is empty. A new strobe afterwards produces a clean frame.
6. Issue 300 drop events. drop_count saturates at 255 and overflow stays at 1.
